// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS instruction-memory boot loader.
package mips_loader_pkg;

   typedef enum logic [2:0] {
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERROR
   } state_t;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
   localparam int unsigned IDX_W          = 2;
   localparam int unsigned LEN_W          = 16;
   localparam int unsigned CNT_W          = LEN_W + 1;

   // Largest word count that fits the memory; a 16-bit length can never exceed 2^16.
   function automatic logic [CNT_W-1:0] max_words(input int unsigned addr_width);
      if (addr_width >= LEN_W) return CNT_W'(1) << LEN_W;
      return CNT_W'(1) << addr_width;
   endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Packs a byte stream into little-endian 32-bit words, one word_valid pulse per word.
module loader_word_packer
   import mips_loader_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic              last_byte_c,
   output logic              word_valid,
   output logic [WORD_W-1:0] word_data
);

   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [WORD_W-BYTE_W-1:0] asm_q, asm_d;
   logic                     word_valid_d;
   logic [WORD_W-1:0]        word_data_d;

   assign last_byte_c = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

   // Earlier bytes shift down so byte 0 ends up in bits 7:0 of the word.
   always_comb begin
      idx_d        = idx_q;
      asm_d        = asm_q;
      word_valid_d = 1'b0;
      word_data_d  = word_data;
      if (clear) begin
         idx_d       = '0;
         asm_d       = '0;
         word_data_d = '0;
      end else if (byte_valid) begin
         if (last_byte_c) begin
            word_data_d  = {byte_data, asm_q};
            word_valid_d = 1'b1;
            idx_d        = '0;
         end else begin
            asm_d = {byte_data, asm_q[WORD_W-BYTE_W-1:BYTE_W]};
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         idx_q      <= '0;
         asm_q      <= '0;
         word_valid <= 1'b0;
         word_data  <= '0;
      end else begin
         idx_q      <= idx_d;
         asm_q      <= asm_d;
         word_valid <= word_valid_d;
         word_data  <= word_data_d;
      end
   end

endmodule

// File: rtl/mips_imem_loader.sv
// Boot loader: receives a framed, XOR-checked image, writes it to instruction
// memory and releases the MIPS core once the image is verified.
module mips_imem_loader
   import mips_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [BYTE_W-1:0]     rx_data,
   output logic                  rx_ready,
   input  logic                  restart,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [WORD_W-1:0]     imem_wdata,
   output logic                  cpu_run,
   output logic                  load_done,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int unsigned         WL_W      = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0]    MAX_WORDS = max_words(ADDR_WIDTH);

   state_t                  state_q, state_d;
   logic [BYTE_W-1:0]       len_lo_q, len_lo_d;
   logic [BYTE_W-1:0]       csum_q, csum_d;
   logic [LEN_W-1:0]        total_q, total_d;
   logic [ADDR_WIDTH-1:0]   addr_d;
   logic [WL_W-1:0]         cnt_d;
   logic                    rx_ready_d, cpu_run_d, load_done_d, load_error_d;
   logic                    hs_c, clear_c, data_byte_c, last_byte_c;
   logic [LEN_W-1:0]        len_c;

   assign hs_c        = rx_valid & rx_ready;
   assign clear_c     = restart & ((state_q == DONE) || (state_q == ERROR));
   assign data_byte_c = hs_c & (state_q == DATA);
   assign len_c       = {rx_data, len_lo_q};

   loader_word_packer u_packer (
      .clock       (clock),
      .reset       (reset),
      .clear       (clear_c),
      .byte_valid  (data_byte_c),
      .byte_data   (rx_data),
      .last_byte_c (last_byte_c),
      .word_valid  (imem_we),
      .word_data   (imem_wdata)
   );

   always_ff @(posedge clock) begin
      if (!reset) state_q <= LEN0;
      else        state_q <= state_d;
   end

   // Next state and next values of every loader register.
   always_comb begin
      state_d  = state_q;
      len_lo_d = len_lo_q;
      csum_d   = csum_q;
      total_d  = total_q;
      cnt_d    = words_loaded;
      addr_d   = imem_addr;
      // Address advances after each write; it holds at the top after a full image.
      if (imem_we && (imem_addr != '1)) addr_d = imem_addr + ADDR_WIDTH'(1);

      unique case (state_q)
         LEN0: begin
            if (hs_c) begin
               len_lo_d = rx_data;
               csum_d   = csum_q ^ rx_data;
               state_d  = LEN1;
            end
         end
         LEN1: begin
            if (hs_c) begin
               total_d = len_c;
               csum_d  = csum_q ^ rx_data;
               if (CNT_W'(len_c) > MAX_WORDS) state_d = ERROR;
               else if (len_c == '0)          state_d = CSUM;
               else                           state_d = DATA;
            end
         end
         DATA: begin
            if (hs_c) begin
               csum_d = csum_q ^ rx_data;
               if (last_byte_c) begin
                  cnt_d = words_loaded + WL_W'(1);
                  if (CNT_W'(words_loaded) + CNT_W'(1) == CNT_W'(total_q)) state_d = CSUM;
               end
            end
         end
         CSUM: begin
            if (hs_c) state_d = (rx_data == csum_q) ? DONE : ERROR;
         end
         DONE, ERROR: begin
            if (restart) begin
               state_d  = LEN0;
               len_lo_d = '0;
               csum_d   = '0;
               total_d  = '0;
               cnt_d    = '0;
               addr_d   = '0;
            end
         end
         default: state_d = LEN0;
      endcase

      rx_ready_d   = (state_d != DONE) && (state_d != ERROR);
      cpu_run_d    = (state_d == DONE);
      load_done_d  = (state_d == DONE);
      load_error_d = (state_d == ERROR);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         len_lo_q     <= '0;
         csum_q       <= '0;
         total_q      <= '0;
         words_loaded <= '0;
         imem_addr    <= '0;
         rx_ready     <= 1'b1;
         cpu_run      <= 1'b0;
         load_done    <= 1'b0;
         load_error   <= 1'b0;
      end else begin
         len_lo_q     <= len_lo_d;
         csum_q       <= csum_d;
         total_q      <= total_d;
         words_loaded <= cnt_d;
         imem_addr    <= addr_d;
         rx_ready     <= rx_ready_d;
         cpu_run      <= cpu_run_d;
         load_done    <= load_done_d;
         load_error   <= load_error_d;
      end
   end

endmodule

// File: tb/tb_mips_imem_loader.sv
// Self-checking bench for mips_imem_loader: frame-level reference model plus directed frames.
module tb_mips_imem_loader;

   localparam int unsigned AW = 8;

   logic          clock;
   logic          reset;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          restart;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_run;
   logic          load_done;
   logic          load_error;
   logic [AW:0]   words_loaded;

   mips_imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clock        (clock),
      .reset        (reset),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .restart      (restart),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_run      (cpu_run),
      .load_done    (load_done),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;
   logic chk_en = 1'b0;

   // Frame-level model: position in the frame decides what each accepted byte means.
   int          m_k, m_n, m_addr, m_words;
   logic [7:0]  m_lo, m_xor;
   logic [31:0] m_word, m_wdata;
   logic        m_done, m_err, m_we;

   always @(posedge clock) begin
      int p;
      m_we = 1'b0;
      if (!reset || ((m_done || m_err) && restart)) begin
         m_k = 0; m_n = 0; m_xor = 8'h00; m_done = 1'b0; m_err = 1'b0; m_words = 0;
      end else if (!(m_done || m_err) && rx_valid) begin
         if (m_k == 0) begin
            m_lo  = rx_data;
            m_xor = m_xor ^ rx_data;
         end else if (m_k == 1) begin
            m_n   = int'({rx_data, m_lo});
            m_xor = m_xor ^ rx_data;
            if (m_n > (1 << AW)) m_err = 1'b1;
         end else if (m_k < 2 + 4 * m_n) begin
            p = (m_k - 2) % 4;
            m_word[p*8 +: 8] = rx_data;
            m_xor = m_xor ^ rx_data;
            if (p == 3) begin
               m_we    = 1'b1;
               m_addr  = (m_k - 2) / 4;
               m_wdata = m_word;
               m_words = m_words + 1;
            end
         end else begin
            if (rx_data == m_xor) m_done = 1'b1;
            else                  m_err  = 1'b1;
         end
         m_k = m_k + 1;
      end
   end

   int          wr_cnt = 0;
   int          wr_addr [0:1023];
   logic [31:0] wr_data [0:1023];
   logic [31:0] img [0:255];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle_compare();
      check("rx_ready", 32'(rx_ready), 32'(!(m_done || m_err)));
      check("imem_we", 32'(imem_we), 32'(m_we));
      if (m_we) begin
         check("imem_addr", 32'(imem_addr), 32'(m_addr));
         check("imem_wdata", imem_wdata, m_wdata);
      end
      check("cpu_run", 32'(cpu_run), 32'(m_done));
      check("load_done", 32'(load_done), 32'(m_done));
      check("load_error", 32'(load_error), 32'(m_err));
      check("words_loaded", 32'(words_loaded), 32'(m_words));
      if (imem_we && wr_cnt < 1024) begin
         wr_addr[wr_cnt] = int'(imem_addr);
         wr_data[wr_cnt] = imem_wdata;
         wr_cnt++;
      end
   endtask

   // Advance one cycle: compare on the falling edge, resume just after the rising edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clock);
         if (chk_en) cycle_compare();
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      rx_valid = 1'b0;
      tick(g);
      rx_valid = 1'b1;
      rx_data  = b;
      tick(1);
      rx_valid = 1'b0;
   endtask

   function automatic logic [7:0] frame_csum(input int n);
      logic [7:0]  x;
      logic [15:0] n16;
      logic [31:0] w;
      n16 = 16'(n);
      x = n16[7:0] ^ n16[15:8];
      for (int i = 0; i < n; i++) begin
         w = img[i];
         x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      end
      return x;
   endfunction

   task automatic send_frame(input int n, input logic [7:0] flip, input int max_gap, input int stop_after);
      logic [7:0]  q[$];
      logic [15:0] n16;
      logic [31:0] w;
      n16 = 16'(n);
      q.push_back(n16[7:0]);
      q.push_back(n16[15:8]);
      for (int i = 0; i < n; i++) begin
         w = img[i];
         for (int j = 0; j < 4; j++) q.push_back(w[j*8 +: 8]);
      end
      q.push_back(frame_csum(n) ^ flip);
      for (int i = 0; i < q.size(); i++) begin
         if (stop_after >= 0 && i >= stop_after) break;
         send_byte(q[i], max_gap);
      end
   endtask

   task automatic do_restart();
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
   endtask

   initial begin
      int base;
      reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; restart = 1'b0;
      tick(1);
      chk_en = 1'b1;
      tick(1);
      check("rst_rx_ready", 32'(rx_ready), 32'd1);
      check("rst_imem_we", 32'(imem_we), 32'd0);
      check("rst_imem_addr", 32'(imem_addr), 32'd0);
      check("rst_imem_wdata", imem_wdata, 32'd0);
      check("rst_cpu_run", 32'(cpu_run), 32'd0);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_load_error", 32'(load_error), 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);
      reset = 1'b1;
      tick(1);
      check("ready_after_reset", 32'(rx_ready), 32'd1);

      // Two-word image with correct checksum.
      img[0] = 32'h20080005;
      img[1] = 32'h01094020;
      check("csum_2words", 32'(frame_csum(2)), 32'h47);
      base = wr_cnt;
      send_frame(2, 8'h00, 0, -1);
      check("t1_done", 32'(load_done), 32'd1);
      check("t1_run", 32'(cpu_run), 32'd1);
      check("t1_words", 32'(words_loaded), 32'd2);
      check("t1_nwr", 32'(wr_cnt - base), 32'd2);
      check("t1_addr0", 32'(wr_addr[base]), 32'd0);
      check("t1_data0", wr_data[base], 32'h20080005);
      check("t1_addr1", 32'(wr_addr[base+1]), 32'd1);
      check("t1_data1", wr_data[base+1], 32'h01094020);
      send_byte(8'hAA, 0);
      check("done_ignores_rx", 32'(words_loaded), 32'd2);

      do_restart();
      check("rs_run", 32'(cpu_run), 32'd0);
      check("rs_done", 32'(load_done), 32'd0);
      check("rs_ready", 32'(rx_ready), 32'd1);
      check("rs_words", 32'(words_loaded), 32'd0);
      check("rs_addr", 32'(imem_addr), 32'd0);
      check("rs_wdata", imem_wdata, 32'd0);

      // Same image, corrupted checksum.
      base = wr_cnt;
      send_frame(2, 8'h01, 0, -1);
      check("t2_error", 32'(load_error), 32'd1);
      check("t2_run", 32'(cpu_run), 32'd0);
      check("t2_ready", 32'(rx_ready), 32'd0);
      check("t2_nwr", 32'(wr_cnt - base), 32'd2);
      check("t2_data1", wr_data[base+1], 32'h01094020);

      // Restart wins over a simultaneous byte; then an empty image.
      restart = 1'b1; rx_valid = 1'b1; rx_data = 8'h00;
      tick(1);
      restart = 1'b0; rx_valid = 1'b0;
      check("rs_err_clear", 32'(load_error), 32'd0);
      base = wr_cnt;
      send_frame(0, 8'h00, 0, -1);
      check("t3_done", 32'(load_done), 32'd1);
      check("t3_nwr", 32'(wr_cnt - base), 32'd0);

      // Oversized length: 257 words.
      do_restart();
      base = wr_cnt;
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      check("t4_error", 32'(load_error), 32'd1);
      check("t4_ready", 32'(rx_ready), 32'd0);
      for (int i = 0; i < 4; i++) send_byte(8'h55, 0);
      check("t4_nwr", 32'(wr_cnt - base), 32'd0);

      // Full 256-word image.
      do_restart();
      for (int i = 0; i < 256; i++) img[i] = $urandom;
      base = wr_cnt;
      send_frame(256, 8'h00, 0, -1);
      check("t5_done", 32'(load_done), 32'd1);
      check("t5_nwr", 32'(wr_cnt - base), 32'd256);
      check("t5_last_addr", 32'(wr_addr[wr_cnt-1]), 32'hFF);
      check("t5_last_data", wr_data[wr_cnt-1], img[255]);
      check("t5_words", 32'(words_loaded), 32'h100);

      // Two-word image again with random valid gaps.
      do_restart();
      img[0] = 32'h20080005;
      img[1] = 32'h01094020;
      base = wr_cnt;
      send_frame(2, 8'h00, 3, -1);
      check("t6_done", 32'(load_done), 32'd1);
      check("t6_nwr", 32'(wr_cnt - base), 32'd2);
      check("t6_addr1", 32'(wr_addr[base+1]), 32'd1);
      check("t6_data0", wr_data[base], 32'h20080005);
      check("t6_data1", wr_data[base+1], 32'h01094020);

      // Reset mid-payload, then a fresh load from address 0.
      do_restart();
      img[2] = 32'hAC0A0004;
      img[3] = 32'h8C0B0004;
      send_frame(4, 8'h00, 0, 7);
      check("t7_partial_words", 32'(words_loaded), 32'd1);
      reset = 1'b0;
      tick(1);
      check("t7_rst_ready", 32'(rx_ready), 32'd1);
      check("t7_rst_words", 32'(words_loaded), 32'd0);
      check("t7_rst_wdata", imem_wdata, 32'd0);
      check("t7_rst_addr", 32'(imem_addr), 32'd0);
      reset = 1'b1;
      tick(1);
      base = wr_cnt;
      send_frame(2, 8'h00, 0, -1);
      check("t7_done", 32'(load_done), 32'd1);
      check("t7_addr0", 32'(wr_addr[base]), 32'd0);
      check("t7_data0", wr_data[base], 32'h20080005);
      check("t7_data1", wr_data[base+1], 32'h01094020);

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
